mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the core's single unified memory port between instruction fetch (IF) and the load/store path (D).
- The D path is driven by the decoded mem_read/mem_write controls.
- Sits between the fetch unit, the LSU and the memory/bus interface.
- Serialises requests with one transaction outstanding at a time.
- Returns each response to the requester that owns the transaction.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; DATA_W/8 byte enables.
- MAX_STARVE, 4, consecutive D grants allowed while IF is waiting (fairness build only); range 1..15.

Ports:
- clk  in  1  core clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- if_req_valid  in  1  fetch request.
- if_req_addr  in  ADDR_W  fetch address.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_rsp_valid  out  1  fetch data valid.
- if_rsp_rdata  out  DATA_W  fetched instruction.
- d_req_valid  in  1  load/store request.
- d_req_we  in  1  1 = store, 0 = load.
- d_req_addr  in  ADDR_W  data address.
- d_req_wdata  in  DATA_W  store data.
- d_req_be  in  DATA_W/8  byte enables.
- d_req_ready  out  1  data request accepted.
- d_rsp_valid  out  1  load data valid, or store acknowledge.
- d_rsp_rdata  out  DATA_W  load data.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  write strobe.
- mem_req_addr  out  ADDR_W  address.
- mem_req_wdata  out  DATA_W  write data.
- mem_req_be  out  DATA_W/8  byte enables.
- mem_rsp_valid  in  1  response valid (reads and writes).
- mem_rsp_rdata  in  DATA_W  read data.

Behaviour:
- States: IDLE, ISSUE, WAIT.
- Reset (rst_n=0 at an edge): state=IDLE, owner=IF, starve count=0, all latched request fields=0.
  - Every *_valid, *_ready and mem_req_* output reads 0 while in IDLE after reset.
  - Reset mid-transaction aborts it; any later mem_rsp_valid that is not in WAIT is ignored.
- IDLE:
  - Grant goes to D if d_req_valid, else to IF if if_req_valid.
  - The granted *_req_ready is asserted combinationally in this cycle only; the other ready stays 0.
  - Request fields and owner are registered; next state is ISSUE. Nothing is granted when no valid is present.
- ISSUE:
  - mem_req_valid=1 with the registered fields, held stable until mem_req_ready=1.
  - An IF transaction drives we=0 and be=all-ones.
  - On handshake, go to WAIT.
  - Both *_req_ready are 0 outside IDLE.
- WAIT:
  - When mem_rsp_valid=1, the owner's rsp_valid=1 combinationally for that cycle, with rdata=mem_rsp_rdata. The other rsp_valid stays 0.
  - Next state is IDLE.
  - A store's response is an ack; d_rsp_rdata is don't-care.
- Latency: accept at T, mem_req_valid at T+1, and rsp no earlier than T+2 when memory answers in the cycle after the handshake. Back-to-back throughput is one transaction per 3 cycles minimum.
- Requester inputs may change freely after ready; the arbiter uses only its latched copy.
- mem_rsp_valid in IDLE or ISSUE is a protocol error. It is ignored and not forwarded.

Optional Feature:
- Macro: MEM_ARB_FAIRNESS_EN.
- Defined:
  - A 4-bit starve counter increments on each D grant made while if_req_valid=1, and clears on any IF grant.
  - When counter==MAX_STARVE and both requesters are valid, IF wins; the counter saturates until then.
- Undefined: strict D priority, with no counter logic present.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2);
  - owner encoding (OWN_IF=1'b0, OWN_D=1'b1);
  - default widths.
- One natural sub-module, mem_arb_grant: the combinational priority decision plus the optional starve counter.
- The FSM and the request/response steering stay in mem_port_arbiter.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both valids high. All readies, rsp_valids and mem_req_valid must stay 0. First grant is to D on the first cycle after release.
- Single fetch: if_req_valid with addr=0x100, mem_req_ready=1, memory responds 1 cycle after handshake with 0x00500093. Required: if_req_ready at T, mem_req_addr=0x100 with we=0 at T+1, if_rsp_valid with 0x00500093 at T+2; d_rsp_valid stays 0.
- Contention: both valid in the same cycle with a store (addr=0x2000, wdata=0xDEADBEEF, be=0xF). Store is issued first and acked via d_rsp_valid; the fetch follows and is answered via if_rsp_valid.
- Backpressure: mem_req_ready low for 5 cycles. mem_req_* stays stable for all 5 cycles, with no new grants.
- Reset mid-WAIT: apply reset in WAIT, then send a stray mem_rsp_valid. No rsp_valid is asserted and state is IDLE.
- Fairness (macro on, MAX_STARVE=4): d_req_valid and if_req_valid held continuously. Grant order is D,D,D,D,IF,D,... Without the macro, IF is never granted.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified memory-port arbiter.
//   - arb_state_t / IDLE, ISSUE, WAIT : arbiter FSM encoding
//   - owner_t / OWN_IF, OWN_D        : which requester owns the transaction
//   - DEF_* widths                   : default parameter values
// No ports (package).
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_MAX_STARVE = 4;

    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE  = 2'd0;
    localparam arb_state_t ISSUE = 2'd1;
    localparam arb_state_t WAIT  = 2'd2;

    typedef logic owner_t;
    localparam owner_t OWN_IF = 1'b0;
    localparam owner_t OWN_D  = 1'b1;

endpackage

// File: rtl/mem_arb_grant.sv
// -----------------------------------------------------------------------------
// mem_arb_grant
// Combinational priority decision between instruction fetch and load/store.
// Default build: strict D priority. With MEM_ARB_FAIRNESS_EN defined, a 4-bit
// starve counter forces an IF grant after MAX_STARVE consecutive D grants made
// while IF was waiting.
// Ports:
//   clk, rst_n   (fairness build only) clock and synchronous active-low reset
//   grant_en     (fairness build only) a grant is actually taken this cycle
//   if_valid     fetch request pending
//   d_valid      load/store request pending
//   grant_valid  some requester is pending
//   grant_owner  requester that wins when grant_valid is set
// -----------------------------------------------------------------------------
module mem_arb_grant
    import mem_arb_pkg::*;
`ifdef MEM_ARB_FAIRNESS_EN
#(
    parameter int MAX_STARVE = DEF_MAX_STARVE
)
`endif
(
`ifdef MEM_ARB_FAIRNESS_EN
    input  logic   clk,
    input  logic   rst_n,
    input  logic   grant_en,
`endif
    input  logic   if_valid,
    input  logic   d_valid,
    output logic   grant_valid,
    output owner_t grant_owner
);

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] starve_q;
    logic [3:0] starve_d;
    logic       if_turn;

    // IF only needs to be forced when D is also competing.
    assign if_turn = (starve_q == 4'(MAX_STARVE)) && if_valid;

    always_comb begin
        grant_valid = if_valid | d_valid;
        grant_owner = (d_valid && !if_turn) ? OWN_D : OWN_IF;
        starve_d    = starve_q;
        if (grant_en && grant_valid) begin
            if (grant_owner == OWN_IF) begin
                starve_d = '0;
            end else if (if_valid && (starve_q != 4'(MAX_STARVE))) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    always_comb begin
        grant_valid = if_valid | d_valid;
        grant_owner = d_valid ? OWN_D : OWN_IF;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one memory port between instruction fetch (IF) and the load/store
// path (D), one transaction outstanding at a time. A request is latched in
// IDLE, presented to memory in ISSUE until accepted, and the response is
// steered back to the owner in WAIT.
// Optional build macro: MEM_ARB_FAIRNESS_EN (starvation guard for IF).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_req_*  / if_rsp_*       fetch request (valid/addr/ready) and response
//   d_req_*   / d_rsp_*        load/store request (valid/we/addr/wdata/be/ready)
//                              and response (valid/rdata; store = ack only)
//   mem_req_* / mem_rsp_*      memory request (valid/ready/we/addr/wdata/be)
//                              and response (valid/rdata)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_STARVE = DEF_MAX_STARVE
)
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_valid,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_req_ready,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_rdata,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_be,
    output logic                d_req_ready,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_be,
    input  logic                mem_rsp_valid,
    input  logic [DATA_W-1:0]   mem_rsp_rdata
);

    localparam int BE_W = DATA_W / 8;

    if (MAX_STARVE < 1 || MAX_STARVE > 15) begin : g_bad_max_starve
        $error("mem_port_arbiter: MAX_STARVE must be within 1..15");
    end

    arb_state_t        state_q, state_d;
    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BE_W-1:0]   be_q,    be_d;

    logic   grant_valid;
    owner_t grant_owner;
    logic   accept_en;
    logic   rsp_fire;

    // Gating with rst_n keeps readies and responses quiet while reset is held.
    assign accept_en = rst_n && (state_q == IDLE);
    assign rsp_fire  = rst_n && (state_q == WAIT) && mem_rsp_valid;

    mem_arb_grant
`ifdef MEM_ARB_FAIRNESS_EN
        #(.MAX_STARVE(MAX_STARVE))
`endif
    u_grant (
`ifdef MEM_ARB_FAIRNESS_EN
        .clk         (clk),
        .rst_n       (rst_n),
        .grant_en    (accept_en),
`endif
        .if_valid    (if_req_valid),
        .d_valid     (d_req_valid),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d = grant_owner;
                    state_d = ISSUE;
                    if (grant_owner == OWN_D) begin
                        addr_d  = d_req_addr;
                        we_d    = d_req_we;
                        wdata_d = d_req_wdata;
                        be_d    = d_req_be;
                    end else begin
                        // Fetches are always full-word reads.
                        addr_d  = if_req_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                        be_d    = '1;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Responses arriving in IDLE/ISSUE are protocol errors and
                // never reach this branch, so they are dropped.
                if (mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the latched request registers are reset too, so mem_req_*
        // reads as zero after reset instead of carrying stale X values.
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= OWN_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value regardless of statement order.
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    assign if_req_ready  = accept_en && grant_valid && (grant_owner == OWN_IF);
    assign d_req_ready   = accept_en && grant_valid && (grant_owner == OWN_D);

    assign mem_req_valid = rst_n && (state_q == ISSUE);
    assign mem_req_we    = we_q;
    assign mem_req_addr  = addr_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_be    = be_q;

    assign if_rsp_valid  = rsp_fire && (owner_q == OWN_IF);
    assign d_rsp_valid   = rsp_fire && (owner_q == OWN_D);
    assign if_rsp_rdata  = mem_rsp_rdata;
    assign d_rsp_rdata   = mem_rsp_rdata;

endmodule
